// File: rtl/crono_ctrl_pkg.sv
// Shared definitions for the crono_ctrl BCD count-up/count-down timer.
// Holds the FSM state encoding and the BCD digit limit.
package crono_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp a preset nibble to a legal BCD digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/crono_ctrl_bcd_digit.sv
// Single BCD digit with up/down step, saturating load and a wrap-out flag.
// co is combinational so that a chained digit steps on the same edge.
module bcd_digit
    import crono_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       co
);

    always_comb begin
        co = en && (dir ? (q == 4'd0) : (q == BCD_MAX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= bcd_sat(ld_val);
        end else if (en) begin
            if (dir) begin
                q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
            end else begin
                q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/crono_ctrl.sv
// Two-digit BCD timer: prescaled step, up/down count, pause/resume, preset.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped, prescaler cleared, digits hold, waiting for start
//   RUN   | prescaler counting, digits step once every DIV cycles
//   PAUSE | stopped by stop, prescaler and digits frozen for resume
//   DONE  | down-count reached 00, waits for clear or load
module crono_ctrl
    import crono_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       tick,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);

    state_t        st;
    logic [PW-1:0] pre;

    logic       in_run;
    logic       step;
    logic       at_zero;
    logic       at_one;
    logic       load_ok;
    logic       underflow;
    logic       dig_ld;
    logic [7:0] dig_ld_val;
    logic       units_co;
    logic       tens_co;

    always_comb begin
        in_run  = (st == RUN);
        step    = in_run && (pre == PRE_TC);
        at_zero = (tens == 4'd0) && (units == 4'd0);
        at_one  = (tens == 4'd0) && (units == 4'd1);
        load_ok = load && !in_run;
        // A borrow out of tens means the count was already 00: reload zeros
        // instead of letting the digits wrap to 99.
        underflow  = dir && tens_co;
        dig_ld     = clear || load_ok || underflow;
        dig_ld_val = (clear || underflow) ? 8'h00 : load_val;
    end

    bcd_digit u_units (
        .clk    (clk),
        .rst    (rst),
        .en     (step),
        .dir    (dir),
        .ld     (dig_ld),
        .ld_val (dig_ld_val[3:0]),
        .q      (units),
        .co     (units_co)
    );

    bcd_digit u_tens (
        .clk    (clk),
        .rst    (rst),
        .en     (units_co),
        .dir    (dir),
        .ld     (dig_ld),
        .ld_val (dig_ld_val[7:4]),
        .q      (tens),
        .co     (tens_co)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= IDLE;
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear || load_ok) begin
                st  <= IDLE;
                pre <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (start) begin
                            pre <= '0;
                            st  <= (dir && at_zero) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (step) begin
                            pre  <= '0;
                            tick <= 1'b1;
                            if (dir && (at_one || underflow)) begin
                                st <= DONE;
                            end else if (stop) begin
                                st <= PAUSE;
                            end
                        end else if (stop) begin
                            st <= PAUSE;
                        end else begin
                            pre <= pre + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            st <= RUN;
                        end
                    end
                    DONE: begin
                    end
                endcase
            end
        end
    end

    assign state   = st;
    assign running = (st == RUN);
    assign done    = (st == DONE);

endmodule

// File: tb/tb_crono_ctrl.sv
// Directed bench for crono_ctrl with CLK_HZ=4, TICK_HZ=1 (four cycles per step).
module tb_crono_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] tens;
    logic [3:0] units;
    logic       tick;
    logic       running;
    logic       done;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    crono_ctrl #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .tens     (tens),
        .units    (units),
        .tick     (tick),
        .running  (running),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            step_clk();
            n++;
        end while (tick !== 1'b1 && n < maxc);
    endtask

    int n;
    int cnt;

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        dir = 1'b0; load = 1'b0; load_val = 8'h00;

        // reset state, start ignored while held in reset
        start = 1'b1;
        repeat (3) step_clk();
        chk("rst_state", state, 2'd0);
        chk("rst_digits", {tens, units}, 8'h00);
        chk("rst_tick", tick, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        start = 1'b0;
        rst = 1'b1;

        // count up from 00: first tick after 4 cycles, 10 ticks -> 10
        dir = 1'b0;
        start = 1'b1; step_clk(); start = 1'b0;
        chk("up_run_state", state, 2'd1);
        chk("up_running", running, 1'b1);
        wait_tick(10, n);
        chk("up_first_latency", n, 4);
        chk("up_first_digits", {tens, units}, 8'h01);
        step_clk();
        chk("up_tick_one_cycle", tick, 1'b0);
        for (int i = 0; i < 9; i++) wait_tick(10, n);
        chk("up_ten_ticks_latency", n, 4);
        chk("up_ten_ticks_digits", {tens, units}, 8'h10);

        // 98 -> 99 -> 00, stays in RUN
        clear = 1'b1; step_clk(); clear = 1'b0;
        chk("clear_state", state, 2'd0);
        chk("clear_digits", {tens, units}, 8'h00);
        load_val = 8'h98; load = 1'b1; step_clk(); load = 1'b0;
        chk("load98_digits", {tens, units}, 8'h98);
        start = 1'b1; step_clk(); start = 1'b0;
        wait_tick(10, n);
        chk("wrap_99", {tens, units}, 8'h99);
        wait_tick(10, n);
        chk("wrap_00", {tens, units}, 8'h00);
        chk("wrap_state_run", state, 2'd1);

        // load ignored during RUN
        load_val = 8'h55; load = 1'b1; step_clk(); load = 1'b0;
        chk("load_in_run_digits", {tens, units}, 8'h00);
        chk("load_in_run_state", state, 2'd1);

        // count down 02 -> 01 -> 00 and DONE
        clear = 1'b1; step_clk(); clear = 1'b0;
        load_val = 8'h02; load = 1'b1; step_clk(); load = 1'b0;
        dir = 1'b1;
        start = 1'b1; step_clk(); start = 1'b0;
        wait_tick(10, n);
        chk("down_01", {tens, units}, 8'h01);
        chk("down_01_state", state, 2'd1);
        wait_tick(10, n);
        chk("down_00", {tens, units}, 8'h00);
        chk("down_done", done, 1'b1);
        chk("down_state", state, 2'd3);
        chk("down_running", running, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step_clk();
            if (tick === 1'b1) cnt++;
        end
        chk("done_no_ticks", cnt, 0);
        chk("done_holds", state, 2'd3);

        // start down from 00 in IDLE goes straight to DONE without a tick
        clear = 1'b1; step_clk(); clear = 1'b0;
        start = 1'b1; step_clk(); start = 1'b0;
        chk("zero_start_state", state, 2'd3);
        chk("zero_start_tick", tick, 1'b0);

        // pause retains prescaler: tick 2 cycles after resume
        clear = 1'b1; step_clk(); clear = 1'b0;
        dir = 1'b0;
        start = 1'b1; step_clk(); start = 1'b0;
        step_clk();
        step_clk();
        stop = 1'b1; step_clk(); stop = 1'b0;
        chk("pause_state", state, 2'd2);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            if (tick === 1'b1) cnt++;
        end
        chk("pause_no_ticks", cnt, 0);
        chk("pause_digits", {tens, units}, 8'h00);
        start = 1'b1; step_clk(); start = 1'b0;
        chk("resume_state", state, 2'd1);
        wait_tick(10, n);
        chk("resume_latency", n, 2);
        chk("resume_digits", {tens, units}, 8'h01);

        // clear beats start in RUN; saturating load
        clear = 1'b1; start = 1'b1; step_clk(); clear = 1'b0; start = 1'b0;
        chk("clr_start_state", state, 2'd0);
        chk("clr_start_digits", {tens, units}, 8'h00);
        load_val = 8'hAF; load = 1'b1; step_clk(); load = 1'b0;
        chk("load_sat_digits", {tens, units}, 8'h99);

        // async reset mid-RUN
        start = 1'b1; step_clk(); start = 1'b0;
        step_clk();
        step_clk();
        #2 rst = 1'b0;
        #1;
        chk("arst_state", state, 2'd0);
        chk("arst_digits", {tens, units}, 8'h00);
        chk("arst_tick", tick, 1'b0);
        chk("arst_running", running, 1'b0);
        chk("arst_done", done, 1'b0);
        start = 1'b1;
        repeat (2) step_clk();
        start = 1'b0;
        rst = 1'b1;
        repeat (6) step_clk();
        chk("post_rst_idle", state, 2'd0);
        chk("post_rst_digits", {tens, units}, 8'h00);
        start = 1'b1; step_clk(); start = 1'b0;
        chk("post_rst_start", state, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
